bp_be_fe_cmd_tx: RTL and testbench
==================================

BP_BE_FE_CMD_TX -- requirements
Module: bp_be_fe_cmd_tx

Interface
REQ-001 SHALL have parameter vaddr_width_p, default 39, virtual PC width.
REQ-002 SHALL have parameter entry_pc_p, default 32'h80000108, boot PC zero-extended to vaddr_width_p.
REQ-003 SHALL have parameter itag_width_p, default 8, command tag width.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port redirect_v_i, input, 1, BE requests PC redirect this cycle.
REQ-007 SHALL have port redirect_pc_i, input, vaddr_width_p, redirect target.
REQ-008 SHALL have port fence_v_i, input, 1, BE requests ITLB fence this cycle.
REQ-009 SHALL have port attaboy_v_i, input, 1, BE reports a correct prediction.
REQ-010 SHALL have port attaboy_pc_i, input, vaddr_width_p, PC of the correctly predicted branch.
REQ-011 SHALL have port ready_o, output, 1, space exists for redirect/fence this cycle.
REQ-012 SHALL have port fe_cmd_o, output, 3+vaddr_width_p+itag_width_p, packed {opcode[2:0], pc, itag}, opcode in MSBs.
REQ-013 SHALL have port fe_cmd_v_o, output, 1, fe_cmd_o valid.
REQ-014 SHALL have port fe_cmd_ready_i, input, 1, FE accepts the command.
REQ-015 SHALL have port drop_o, output, 1, one-cycle pulse when a request is discarded.

Function
REQ-016 SHALL encode opcodes 0 state_reset, 1 pc_redirect, 2 attaboy, 3 itlb_fence; fence pc field 0.
REQ-017 SHALL hold commands in a 2-entry FIFO; fe_cmd_o/fe_cmd_v_o driven from the head entry only.
REQ-018 SHALL transfer a command on a cycle where fe_cmd_v_o and fe_cmd_ready_i are both 1; head pops same edge.
REQ-019 SHALL keep fe_cmd_o stable while fe_cmd_v_o=1 and fe_cmd_ready_i=0.
REQ-020 SHALL present an enqueued command on fe_cmd_v_o no earlier than the cycle after enqueue (no bypass).
REQ-021 SHALL drive ready_o=1 iff FSM is RUN and FIFO holds fewer than 2 entries, or holds 2 and pops this cycle.
REQ-022 SHALL enqueue at most one command per cycle, priority redirect > fence > attaboy.
REQ-023 SHALL pulse drop_o when a lower-priority valid request loses to a higher one, or any request arrives while ready_o=0.
REQ-024 SHALL assign each enqueued command the current itag, then increment itag modulo 2^itag_width_p (8'hFF wraps to 8'h00).
REQ-025 SHALL implement FSM states BOOT and RUN; BOOT enqueues one state_reset command with pc=entry_pc_p, then moves to RUN next cycle.
REQ-026 SHALL ignore and drop all BE requests in BOOT.
REQ-027 SHALL handle simultaneous enqueue and pop with full FIFO without loss or reorder.

Reset
REQ-028 SHALL on reset_i=1 clear FIFO, set itag 0, FSM BOOT, fe_cmd_v_o=0, ready_o=0, drop_o=0.
REQ-029 SHALL on reset asserted mid-transfer discard all queued commands; no command survives reset.
REQ-030 SHALL emit the state_reset command (itag 0) on fe_cmd_v_o two cycles after reset_i deasserts.

Configuration
REQ-031 SHALL with BP_BE_FE_CMD_ATTABOY_EN defined enqueue attaboy commands per REQ-022.
REQ-032 SHALL without BP_BE_FE_CMD_ATTABOY_EN ignore attaboy_v_i entirely: never enqueued, never causes drop_o, itag unaffected.

Verification
REQ-033 SHALL test boot: release reset, fe_cmd_ready_i=1 -> cycle 2 opcode 0, pc 0x80000108, itag 0; ready_o=1 from cycle 2.
REQ-034 SHALL test backpressure: fe_cmd_ready_i=0, redirects to 0x1000, 0x2000, 0x3000 -> first two queued, third drop_o=1, ready_o=0; release -> 0x1000 then 0x2000 in order.
REQ-035 SHALL test priority: redirect 0x4000, fence, attaboy same cycle -> only redirect enqueued, drop_o=1.
REQ-036 SHALL test itag wrap: 256 commands after boot -> tags 1..255 then 0, monotonic modulo 256.
REQ-037 SHALL test reset mid-operation: reset with 2 queued and fe_cmd_v_o=1 -> fe_cmd_v_o=0 next cycle, queue empty, fresh state_reset itag 0 after.
REQ-038 SHALL test configuration: attaboy 0x5000 alone -> opcode 2 emitted with macro; nothing emitted, drop_o=0 without.

Source files
------------

// File: rtl/bp_be_fe_cmd_tx.sv
// Back-end to front-end command transmitter: arbitrates BE requests into a 2-entry command FIFO.
// Optional feature macro: BP_BE_FE_CMD_ATTABOY_EN (enables attaboy command generation).
module bp_be_fe_cmd_tx #(
    parameter int vaddr_width_p = 39,
    parameter logic [vaddr_width_p-1:0] entry_pc_p = vaddr_width_p'(32'h80000108),
    parameter int itag_width_p = 8
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic                                       redirect_v_i,
    input  logic [vaddr_width_p-1:0]                   redirect_pc_i,
    input  logic                                       fence_v_i,
    input  logic                                       attaboy_v_i,
    input  logic [vaddr_width_p-1:0]                   attaboy_pc_i,
    output logic                                       ready_o,
    output logic [3+vaddr_width_p+itag_width_p-1:0]    fe_cmd_o,
    output logic                                       fe_cmd_v_o,
    input  logic                                       fe_cmd_ready_i,
    output logic                                       drop_o
);

    // state | meaning
    // BOOT  | after reset; waits one cycle, then posts the state_reset command
    // RUN   | accepts redirect / fence / attaboy requests from the BE

    localparam int cmd_width_lp = 3 + vaddr_width_p + itag_width_p;

    localparam logic [2:0] op_state_reset = 3'd0;
    localparam logic [2:0] op_pc_redirect = 3'd1;
    localparam logic [2:0] op_attaboy     = 3'd2;
    localparam logic [2:0] op_itlb_fence  = 3'd3;

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

    state_e                     state_q;
    logic                       boot_wait_q;
    logic [cmd_width_lp-1:0]    mem_q [2];
    logic                       rd_ptr_q;
    logic                       wr_ptr_q;
    logic [1:0]                 count_q;
    logic [itag_width_p-1:0]    itag_q;

    logic                       attaboy_v;
    logic [vaddr_width_p-1:0]   attaboy_pc;
    logic                       pop;
    logic                       enq;
    logic [2:0]                 enq_op;
    logic [vaddr_width_p-1:0]   enq_pc;
    logic [1:0]                 req_cnt;

`ifdef BP_BE_FE_CMD_ATTABOY_EN
    assign attaboy_v  = attaboy_v_i;
    assign attaboy_pc = attaboy_pc_i;
`else
    logic unused_attaboy;
    assign unused_attaboy = ^{attaboy_v_i, attaboy_pc_i};
    assign attaboy_v  = 1'b0;
    assign attaboy_pc = '0;
`endif

    assign fe_cmd_v_o = (count_q != 2'd0);
    assign fe_cmd_o   = mem_q[rd_ptr_q];
    assign pop        = fe_cmd_v_o && fe_cmd_ready_i;

    // A full FIFO can still accept when the head leaves on the same edge.
    assign ready_o = !reset_i && (state_q == RUN) && ((count_q != 2'd2) || pop);

    assign req_cnt = 2'(redirect_v_i) + 2'(fence_v_i) + 2'(attaboy_v);
    assign drop_o  = !reset_i && (ready_o ? (req_cnt > 2'd1) : (req_cnt != 2'd0));

    always_comb begin
        enq    = 1'b0;
        enq_op = op_state_reset;
        enq_pc = '0;
        if (state_q == BOOT) begin
            if (boot_wait_q) begin
                enq    = 1'b1;
                enq_pc = entry_pc_p;
            end
        end else if (ready_o) begin
            if (redirect_v_i) begin
                enq    = 1'b1;
                enq_op = op_pc_redirect;
                enq_pc = redirect_pc_i;
            end else if (fence_v_i) begin
                enq    = 1'b1;
                enq_op = op_itlb_fence;
            end else if (attaboy_v) begin
                enq    = 1'b1;
                enq_op = op_attaboy;
                enq_pc = attaboy_pc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= BOOT;
            boot_wait_q <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            itag_q      <= '0;
        end else begin
            if (state_q == BOOT) begin
                boot_wait_q <= 1'b1;
                if (boot_wait_q) begin
                    state_q <= RUN;
                end
            end
            if (enq) begin
                wr_ptr_q <= ~wr_ptr_q;
                itag_q   <= itag_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(enq) - 2'(pop);
        end
    end

    // Storage needs no reset: count_q gates visibility of every entry.
    always_ff @(posedge clk_i) begin
        if (!reset_i && enq) begin
            mem_q[wr_ptr_q] <= {enq_op, enq_pc, itag_q};
        end
    end

endmodule

// File: tb/tb_bp_be_fe_cmd_tx.sv
// Self-checking bench for bp_be_fe_cmd_tx: vector table, hand sequences and a queue-based random model.
// Honours BP_BE_FE_CMD_ATTABOY_EN the same way the design does.
module tb_bp_be_fe_cmd_tx;

    localparam int VW = 39;
    localparam int IW = 8;
    localparam int CW = 3 + VW + IW;
    localparam logic [VW-1:0] ENTRY_PC = 39'h0080000108;

`ifdef BP_BE_FE_CMD_ATTABOY_EN
    localparam bit ATTA_EN = 1'b1;
`else
    localparam bit ATTA_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i;
    logic          redirect_v_i;
    logic [VW-1:0] redirect_pc_i;
    logic          fence_v_i;
    logic          attaboy_v_i;
    logic [VW-1:0] attaboy_pc_i;
    logic          ready_o;
    logic [CW-1:0] fe_cmd_o;
    logic          fe_cmd_v_o;
    logic          fe_cmd_ready_i;
    logic          drop_o;

    bp_be_fe_cmd_tx dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .redirect_v_i   (redirect_v_i),
        .redirect_pc_i  (redirect_pc_i),
        .fence_v_i      (fence_v_i),
        .attaboy_v_i    (attaboy_v_i),
        .attaboy_pc_i   (attaboy_pc_i),
        .ready_o        (ready_o),
        .fe_cmd_o       (fe_cmd_o),
        .fe_cmd_v_o     (fe_cmd_v_o),
        .fe_cmd_ready_i (fe_cmd_ready_i),
        .drop_o         (drop_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [IW-1:0] exp_itag;

    typedef struct {
        logic          rv;
        logic [VW-1:0] rpc;
        logic          fv;
        logic          av;
        logic [VW-1:0] apc;
        logic          exp_drop;
        logic          exp_enq;
        logic [2:0]    exp_op;
        logic [VW-1:0] exp_pc;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [CW-1:0] mk(input logic [2:0] op, input logic [VW-1:0] pc,
                                         input logic [IW-1:0] tag);
        return {op, pc, tag};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkc(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got op=%0d pc=%0h tag=%0h expected op=%0d pc=%0h tag=%0h",
                     name, act[CW-1 -: 3], act[IW +: VW], act[IW-1:0],
                     exp[CW-1 -: 3], exp[IW +: VW], exp[IW-1:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        redirect_v_i  = 1'b0;
        redirect_pc_i = '0;
        fence_v_i     = 1'b0;
        attaboy_v_i   = 1'b0;
        attaboy_pc_i  = '0;
    endtask

    // Called at a negedge with reset_i high; leaves the queue empty and exp_itag = 1.
    task automatic do_boot();
        idle();
        fe_cmd_ready_i = 1'b1;
        reset_i = 1'b0;
        #1;
        chk1("boot_c0_v", fe_cmd_v_o, 1'b0);
        chk1("boot_c0_ready", ready_o, 1'b0);
        tick();
        redirect_v_i  = 1'b1;
        redirect_pc_i = 39'h777;
        #1;
        chk1("boot_c1_v", fe_cmd_v_o, 1'b0);
        chk1("boot_c1_ready", ready_o, 1'b0);
        chk1("boot_c1_drop", drop_o, 1'b1);
        tick();
        idle();
        #1;
        chk1("boot_c2_v", fe_cmd_v_o, 1'b1);
        chkc("boot_c2_cmd", fe_cmd_o, mk(3'd0, ENTRY_PC, 8'h00));
        chk1("boot_c2_ready", ready_o, 1'b1);
        tick();
        #1;
        chk1("boot_c3_empty", fe_cmd_v_o, 1'b0);
        exp_itag = 8'h01;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]    t_op;
        logic [VW-1:0] t_pc;
        logic [IW-1:0] t0;
        logic [CW-1:0] q [$];
        logic [63:0]   r;

        vecs[0] = '{1'b1, 39'h4000, 1'b1, 1'b1, 39'h5000, 1'b1,    1'b1,    3'd1, 39'h4000};
        vecs[1] = '{1'b0, 39'h0,    1'b1, 1'b0, 39'h0,    1'b0,    1'b1,    3'd3, 39'h0};
        vecs[2] = '{1'b0, 39'h0,    1'b0, 1'b1, 39'h5000, 1'b0,    ATTA_EN, 3'd2, 39'h5000};
        vecs[3] = '{1'b0, 39'h0,    1'b1, 1'b1, 39'h5123, ATTA_EN, 1'b1,    3'd3, 39'h0};
        vecs[4] = '{1'b1, 39'h8888, 1'b0, 1'b1, 39'h9999, ATTA_EN, 1'b1,    3'd1, 39'h8888};
        vecs[5] = '{1'b1, 39'hABC0, 1'b1, 1'b0, 39'h0,    1'b1,    1'b1,    3'd1, 39'hABC0};
        vecs[6] = '{1'b0, 39'h0,    1'b0, 1'b0, 39'h0,    1'b0,    1'b0,    3'd0, 39'h0};
        vecs[7] = '{1'b1, {VW{1'b1}}, 1'b0, 1'b0, 39'h0,  1'b0,    1'b1,    3'd1, {VW{1'b1}}};

        reset_i = 1'b1;
        fe_cmd_ready_i = 1'b0;
        idle();
        tick();
        tick();
        redirect_v_i = 1'b1;
        fence_v_i    = 1'b1;
        #1;
        chk1("reset_v", fe_cmd_v_o, 1'b0);
        chk1("reset_ready", ready_o, 1'b0);
        chk1("reset_drop", drop_o, 1'b0);
        tick();

        do_boot();

        for (int i = 0; i < 8; i++) begin
            redirect_v_i  = vecs[i].rv;
            redirect_pc_i = vecs[i].rpc;
            fence_v_i     = vecs[i].fv;
            attaboy_v_i   = vecs[i].av;
            attaboy_pc_i  = vecs[i].apc;
            fe_cmd_ready_i = 1'b1;
            #1;
            chk1($sformatf("vec%0d_ready", i), ready_o, 1'b1);
            chk1($sformatf("vec%0d_drop", i), drop_o, vecs[i].exp_drop);
            tick();
            idle();
            #1;
            chk1($sformatf("vec%0d_v", i), fe_cmd_v_o, vecs[i].exp_enq);
            if (vecs[i].exp_enq) begin
                chkc($sformatf("vec%0d_cmd", i), fe_cmd_o, mk(vecs[i].exp_op, vecs[i].exp_pc, exp_itag));
                exp_itag = exp_itag + 1'b1;
            end
            tick();
        end

        // Backpressure: two queue, third drops, order preserved.
        t0 = exp_itag;
        fe_cmd_ready_i = 1'b0;
        redirect_v_i = 1'b1; redirect_pc_i = 39'h1000;
        #1;
        chk1("bp1_ready", ready_o, 1'b1);
        chk1("bp1_drop", drop_o, 1'b0);
        tick();
        redirect_pc_i = 39'h2000;
        #1;
        chk1("bp2_ready", ready_o, 1'b1);
        chk1("bp2_drop", drop_o, 1'b0);
        chkc("bp2_head", fe_cmd_o, mk(3'd1, 39'h1000, t0));
        tick();
        redirect_pc_i = 39'h3000;
        #1;
        chk1("bp3_ready", ready_o, 1'b0);
        chk1("bp3_drop", drop_o, 1'b1);
        chkc("bp3_head_stable", fe_cmd_o, mk(3'd1, 39'h1000, t0));
        tick();
        idle();
        fe_cmd_ready_i = 1'b1;
        #1;
        chkc("bp4_first", fe_cmd_o, mk(3'd1, 39'h1000, t0));
        chk1("bp4_ready_full_pop", ready_o, 1'b1);
        tick();
        #1;
        chkc("bp5_second", fe_cmd_o, mk(3'd1, 39'h2000, t0 + 8'd1));
        tick();
        #1;
        chk1("bp6_empty", fe_cmd_v_o, 1'b0);
        exp_itag = t0 + 8'd2;

        // Full FIFO with simultaneous enqueue and pop.
        t0 = exp_itag;
        fe_cmd_ready_i = 1'b0;
        fence_v_i = 1'b1;
        tick();
        idle();
        redirect_v_i = 1'b1; redirect_pc_i = 39'h1111;
        tick();
        fe_cmd_ready_i = 1'b1;
        redirect_pc_i = 39'h6000;
        #1;
        chk1("fp_ready", ready_o, 1'b1);
        chk1("fp_drop", drop_o, 1'b0);
        chkc("fp_head0", fe_cmd_o, mk(3'd3, 39'h0, t0));
        tick();
        idle();
        #1;
        chkc("fp_head1", fe_cmd_o, mk(3'd1, 39'h1111, t0 + 8'd1));
        tick();
        #1;
        chkc("fp_head2", fe_cmd_o, mk(3'd1, 39'h6000, t0 + 8'd2));
        tick();
        #1;
        chk1("fp_empty", fe_cmd_v_o, 1'b0);

        // itag wrap: fresh boot, then 256 redirects -> tags 1..255, 0.
        reset_i = 1'b1;
        tick();
        do_boot();
        for (int k = 0; k <= 256; k++) begin
            redirect_v_i  = (k < 256);
            redirect_pc_i = VW'(k);
            fe_cmd_ready_i = 1'b1;
            #1;
            if (k > 0) begin
                chkc($sformatf("wrap%0d", k), fe_cmd_o, mk(3'd1, VW'(k - 1), IW'(k)));
            end
            tick();
        end
        idle();

        // Reset mid-operation with two commands queued.
        fe_cmd_ready_i = 1'b0;
        redirect_v_i = 1'b1; redirect_pc_i = 39'hAAA0;
        tick();
        redirect_pc_i = 39'hBBB0;
        tick();
        idle();
        #1;
        chk1("rmid_pre_v", fe_cmd_v_o, 1'b1);
        reset_i = 1'b1;
        tick();
        #1;
        chk1("rmid_v", fe_cmd_v_o, 1'b0);
        chk1("rmid_ready", ready_o, 1'b0);
        chk1("rmid_drop", drop_o, 1'b0);
        do_boot();

        // Random traffic against a queue model.
        q = {};
        for (int c = 0; c < 2000; c++) begin
            logic pop_m, ready_m, drop_m;
            int nreq;
            redirect_v_i = ($urandom_range(0, 99) < 30);
            fence_v_i    = ($urandom_range(0, 99) < 20);
            attaboy_v_i  = ($urandom_range(0, 99) < 30);
            r = {$urandom(), $urandom()};
            redirect_pc_i = r[VW-1:0];
            r = {$urandom(), $urandom()};
            attaboy_pc_i = r[VW-1:0];
            fe_cmd_ready_i = ($urandom_range(0, 99) < 50);

            pop_m   = (q.size() > 0) && fe_cmd_ready_i;
            ready_m = (q.size() < 2) || pop_m;
            nreq    = int'(redirect_v_i) + int'(fence_v_i) + int'(ATTA_EN && attaboy_v_i);
            drop_m  = ready_m ? (nreq > 1) : (nreq > 0);
            #1;
            chk1("rnd_ready", ready_o, ready_m);
            chk1("rnd_drop", drop_o, drop_m);
            chk1("rnd_v", fe_cmd_v_o, q.size() > 0);
            if (q.size() > 0) begin
                chkc("rnd_cmd", fe_cmd_o, q[0]);
            end
            if (pop_m) void'(q.pop_front());
            if (ready_m && nreq > 0) begin
                if (redirect_v_i) begin
                    t_op = 3'd1; t_pc = redirect_pc_i;
                end else if (fence_v_i) begin
                    t_op = 3'd3; t_pc = '0;
                end else begin
                    t_op = 3'd2; t_pc = attaboy_pc_i;
                end
                q.push_back(mk(t_op, t_pc, exp_itag));
                exp_itag = exp_itag + 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
